// File: rtl/qam_pkg.sv
// Shared QAM constants and helpers, used by both the symbol generator and the demapper.
//   qam_axis_bits(m) : bits per axis, A = log2(M)/2
//   qam_levels(m)    : amplitude levels per axis, L = 2^A
//   qam_params_ok    : true when log2(M) is even, M is a power of two and W >= A+1
package qam_pkg;

    localparam int unsigned QAM_M_DEFAULT = 256;
    localparam int unsigned QAM_W_DEFAULT = 8;

    function automatic int unsigned qam_axis_bits(input int unsigned m);
        return $clog2(m) / 2;
    endfunction

    function automatic int unsigned qam_levels(input int unsigned m);
        return 32'd1 << qam_axis_bits(m);
    endfunction

    function automatic bit qam_params_ok(input int unsigned m, input int unsigned w);
        return (m >= 4) && (m == (32'd1 << $clog2(m))) && (($clog2(m) % 2) == 0)
               && (w >= qam_axis_bits(m) + 1);
    endfunction

endpackage

// File: rtl/qam_axis_slicer.sv
// One-axis hard slicer with two register stages.
//   stage1: raw index floor((s + L)/2), clip flag, sample   (loads on s1_en)
//   stage2: clamped index and residual sample - point       (loads on s2_en)
// INVERT=1 slices the imaginary axis, whose generator map is negated.
// Ports: clk, rst (sync, active-high), s1_en, s2_en, sample (W signed),
//        clip_s1 (stage1 clip flag), idx (A bits), err (W signed).
module qam_axis_slicer
    import qam_pkg::*;
#(
    parameter int unsigned M      = QAM_M_DEFAULT,
    parameter int unsigned W      = QAM_W_DEFAULT,
    parameter logic        INVERT = 1'b0,
    localparam int unsigned A     = qam_axis_bits(M)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s1_en,
    input  logic                s2_en,
    input  logic signed [W-1:0] sample,
    output logic                clip_s1,
    output logic [A-1:0]        idx,
    output logic signed [W-1:0] err
);
    localparam int unsigned L  = qam_levels(M);
    localparam int unsigned XW = W + 2;
    localparam logic signed [XW-1:0] L_X   = XW'(L);
    localparam logic signed [XW-1:0] MAX_X = XW'(L - 1);

    logic signed [W-1:0]  samp_q, samp_d;
    logic signed [XW-1:0] raw_q, raw_d;
    logic                 clip_q, clip_d;
    logic [A-1:0]         idx_q, idx_d;
    logic signed [W-1:0]  err_q, err_d;

    logic signed [XW-1:0] s_ext, s_ax, samp_ext, idx_x, pt_ax, pt, err_full;

    // Stage 1: raw decision; arithmetic shift gives floor for negative sums
    always_comb begin
        samp_d = samp_q;
        raw_d  = raw_q;
        clip_d = clip_q;
        s_ext  = {{2{sample[W-1]}}, sample};
        s_ax   = INVERT ? -s_ext : s_ext;
        if (s1_en) begin
            samp_d = sample;
            raw_d  = (s_ax + L_X) >>> 1;
            clip_d = raw_d[XW-1] || (raw_d > MAX_X);
        end
    end

    // Stage 2: clamp, rebuild the constellation point and form the residual
    always_comb begin
        idx_d    = idx_q;
        err_d    = err_q;
        samp_ext = {{2{samp_q[W-1]}}, samp_q};
        if (raw_q[XW-1]) begin
            idx_x = '0;
        end else if (raw_q > MAX_X) begin
            idx_x = MAX_X;
        end else begin
            idx_x = raw_q;
        end
        pt_ax    = (idx_x <<< 1) - MAX_X;
        pt       = INVERT ? -pt_ax : pt_ax;
        err_full = samp_ext - pt;
        if (s2_en) begin
            idx_d = idx_x[A-1:0];
            err_d = err_full[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= '0;
            raw_q  <= '0;
            clip_q <= 1'b0;
            idx_q  <= '0;
            err_q  <= '0;
        end else begin
            samp_q <= samp_d;
            raw_q  <= raw_d;
            clip_q <= clip_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
        end
    end

    assign clip_s1 = clip_q;
    assign idx     = idx_q;
    assign err     = err_q;

endmodule

// File: rtl/qam_demod_slicer.sv
// Hard-decision QAM demapper for N parallel lanes, fixed latency 2, no backpressure.
// Ports: clk, rst (sync, active-high), valid_in, re_in/im_in (W signed per lane),
//        clr_stats; data_out (log2(M) bits per lane: ri low, qi high), err_re/err_im
//        (W signed per lane), valid_out, sym_count, clip_count (saturating).
module qam_demod_slicer
    import qam_pkg::*;
#(
    parameter int unsigned M     = 256,
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 1,
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [W*N-1:0]   re_in,
    input  logic signed [W*N-1:0]   im_in,
    input  logic                    clr_stats,
    output logic [$clog2(M)*N-1:0]  data_out,
    output logic signed [W*N-1:0]   err_re,
    output logic signed [W*N-1:0]   err_im,
    output logic                    valid_out,
    output logic [CNT_W-1:0]        sym_count,
    output logic [CNT_W-1:0]        clip_count
);
    localparam int unsigned A = qam_axis_bits(M);
    localparam int unsigned B = 2 * A;

    if (!qam_params_ok(M, W)) begin : g_bad_params
        $error("qam_demod_slicer: log2(M) must be even and W >= log2(M)/2 + 1");
    end

    logic v1_q, v1_d, v2_q, v2_d;
    logic [N-1:0] clip_re_s1, clip_im_s1;
    logic any_clip;
    logic [CNT_W-1:0] sym_q, sym_d, clip_q, clip_d;

    for (genvar i = 0; i < N; i++) begin : g_lane
        qam_axis_slicer #(.M(M), .W(W), .INVERT(1'b0)) u_re (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (valid_in),
            .s2_en   (v1_q),
            .sample  (re_in[W*i +: W]),
            .clip_s1 (clip_re_s1[i]),
            .idx     (data_out[B*i +: A]),
            .err     (err_re[W*i +: W])
        );
        qam_axis_slicer #(.M(M), .W(W), .INVERT(1'b1)) u_im (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (valid_in),
            .s2_en   (v1_q),
            .sample  (im_in[W*i +: W]),
            .clip_s1 (clip_im_s1[i]),
            .idx     (data_out[B*i + A +: A]),
            .err     (err_im[W*i +: W])
        );
    end

    assign any_clip = |{clip_re_s1, clip_im_s1};

    // Valid pipeline and statistics; counters advance as a beat enters stage 2,
    // so they change on the same edge that raises valid_out
    always_comb begin
        v1_d   = valid_in;
        v2_d   = v1_q;
        sym_d  = sym_q;
        clip_d = clip_q;
        if (clr_stats) begin
            sym_d  = '0;
            clip_d = '0;
        end
        if (v1_q) begin
            if (sym_d != '1) begin
                sym_d = sym_d + CNT_W'(1);
            end
            if (any_clip && (clip_d != '1)) begin
                clip_d = clip_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            sym_q  <= '0;
            clip_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            sym_q  <= sym_d;
            clip_q <= clip_d;
        end
    end

    assign valid_out  = v2_q;
    assign sym_count  = sym_q;
    assign clip_count = clip_q;

endmodule

// File: tb/tb_qam_demod_slicer.sv
// Bench for qam_demod_slicer: instance A (M=16, N=2, CNT_W=4) and instance B (M=256, N=1).
// Expected beats come from a nearest-point search model and are checked by a
// scoreboard monitor on the falling edge, including the cycle of arrival.
module tb_qam_demod_slicer;
    localparam int unsigned W  = 8;
    localparam int          LA = 4;
    localparam int          LB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               valid_a = 1'b0, clr_a = 1'b0;
    logic signed [15:0] re_a = '0, im_a = '0;
    logic [7:0]         data_a;
    logic signed [15:0] err_re_a, err_im_a;
    logic               vo_a;
    logic [3:0]         sym_a, clip_a;

    logic               valid_b = 1'b0, clr_b = 1'b0;
    logic signed [7:0]  re_b = '0, im_b = '0;
    logic [7:0]         data_b;
    logic signed [7:0]  err_re_b, err_im_b;
    logic               vo_b;
    logic [31:0]        sym_b, clip_b;

    qam_demod_slicer #(.M(16), .W(W), .N(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_a), .re_in(re_a), .im_in(im_a),
        .clr_stats(clr_a), .data_out(data_a), .err_re(err_re_a), .err_im(err_im_a),
        .valid_out(vo_a), .sym_count(sym_a), .clip_count(clip_a)
    );

    qam_demod_slicer #(.M(256), .W(W), .N(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_b), .re_in(re_b), .im_in(im_b),
        .clr_stats(clr_b), .data_out(data_b), .err_re(err_re_b), .err_im(err_im_b),
        .valid_out(vo_b), .sym_count(sym_b), .clip_count(clip_b)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] ere;
        logic [15:0] eim;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_sym_a = 0, exp_clip_a = 0, exp_sym_b = 0, exp_clip_b = 0;
    logic [7:0] last_data_a;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Exhaustive nearest-point search; ties go to the higher index
    function automatic void model_lane(input int l, input int re, input int im,
                                       output int ri, output int qi,
                                       output int ere, output int eim, output bit clip);
        int bd;
        bd = -1; ri = 0; qi = 0;
        for (int k = 0; k < l; k++) begin
            if (bd < 0 || iabs(re - (2*k - l + 1)) <= bd) begin
                bd = iabs(re - (2*k - l + 1)); ri = k;
            end
        end
        bd = -1;
        for (int k = 0; k < l; k++) begin
            if (bd < 0 || iabs(im + (2*k - l + 1)) <= bd) begin
                bd = iabs(im + (2*k - l + 1)); qi = k;
            end
        end
        ere  = re - (2*ri - l + 1);
        eim  = im + (2*qi - l + 1);
        clip = (re < -l) || (re >= l) || (-im < -l) || (-im >= l);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int re0, input int im0, input int re1, input int im1,
                          input bit keep);
        int ri0, qi0, e0r, e0i, ri1, qi1, e1r, e1i;
        bit c0, c1;
        exp_t e;
        valid_a = 1'b1;
        re_a = {8'(re1), 8'(re0)};
        im_a = {8'(im1), 8'(im0)};
        if (keep) begin
            model_lane(LA, re0, im0, ri0, qi0, e0r, e0i, c0);
            model_lane(LA, re1, im1, ri1, qi1, e1r, e1i, c1);
            e.data = {2'(qi1), 2'(ri1), 2'(qi0), 2'(ri0)};
            e.ere  = {8'(e1r), 8'(e0r)};
            e.eim  = {8'(e1i), 8'(e0i)};
            e.cyc  = cyc + 2;
            q_a.push_back(e);
            last_data_a = e.data;
            if (exp_sym_a < 15) exp_sym_a++;
            if ((c0 || c1) && exp_clip_a < 15) exp_clip_a++;
        end
        tick();
        valid_a = 1'b0;
    endtask

    task automatic send_b(input int re, input int im);
        int ri, qi, er, ei;
        bit c;
        exp_t e;
        valid_b = 1'b1;
        re_b = 8'(re);
        im_b = 8'(im);
        model_lane(LB, re, im, ri, qi, er, ei, c);
        e.data = {4'(qi), 4'(ri)};
        e.ere  = {8'd0, 8'(er)};
        e.eim  = {8'd0, 8'(ei)};
        e.cyc  = cyc + 2;
        q_b.push_back(e);
        exp_sym_b++;
        if (c) exp_clip_b++;
        tick();
        valid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for all expected beats, then let the counters settle
    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        idle(2);
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: beats outstanding a=%0d b=%0d, required 0", q_a.size(), q_b.size());
        end
    endtask

    always @(negedge clk) begin
        if (vo_a === 1'b1) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL beat_a: unexpected valid_out at cycle %0d data=%h", cyc, data_a);
            end else begin
                ea = q_a.pop_front();
                if (data_a !== ea.data || err_re_a !== ea.ere || err_im_a !== ea.eim || cyc != ea.cyc) begin
                    n_bad++;
                    $display("FAIL beat_a: got data=%h ere=%h eim=%h cyc=%0d, required data=%h ere=%h eim=%h cyc=%0d",
                             data_a, err_re_a, err_im_a, cyc, ea.data, ea.ere, ea.eim, ea.cyc);
                end
            end
        end
        if (vo_b === 1'b1) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL beat_b: unexpected valid_out at cycle %0d data=%h", cyc, data_b);
            end else begin
                eb = q_b.pop_front();
                if (data_b !== eb.data || err_re_b !== eb.ere[7:0] || err_im_b !== eb.eim[7:0] || cyc != eb.cyc) begin
                    n_bad++;
                    $display("FAIL beat_b: got data=%h ere=%h eim=%h cyc=%0d, required data=%h ere=%h eim=%h cyc=%0d",
                             data_b, err_re_b, err_im_b, cyc, eb.data, eb.ere[7:0], eb.eim[7:0], eb.cyc);
                end
            end
        end
    end

    task automatic check_counts(input string name);
        n_vec++;
        if (sym_a !== 4'(exp_sym_a) || clip_a !== 4'(exp_clip_a)) begin
            n_bad++;
            $display("FAIL %s counts_a: got sym=%0d clip=%0d, required sym=%0d clip=%0d",
                     name, sym_a, clip_a, exp_sym_a, exp_clip_a);
        end
        n_vec++;
        if (sym_b !== 32'(exp_sym_b) || clip_b !== 32'(exp_clip_b)) begin
            n_bad++;
            $display("FAIL %s counts_b: got sym=%0d clip=%0d, required sym=%0d clip=%0d",
                     name, sym_b, clip_b, exp_sym_b, exp_clip_b);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({vo_a, data_a, err_re_a, err_im_a, sym_a, clip_a} !== '0) begin
            n_bad++;
            $display("FAIL %s zero_a: got v=%b d=%h er=%h ei=%h s=%0d c=%0d, required all 0",
                     name, vo_a, data_a, err_re_a, err_im_a, sym_a, clip_a);
        end
        n_vec++;
        if ({vo_b, data_b, err_re_b, err_im_b, sym_b, clip_b} !== '0) begin
            n_bad++;
            $display("FAIL %s zero_b: got v=%b d=%h er=%h ei=%h s=%0d c=%0d, required all 0",
                     name, vo_b, data_b, err_re_b, err_im_b, sym_b, clip_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        check_zero("reset");
        rst = 1'b0;
        exp_sym_a = 0; exp_clip_a = 0; exp_sym_b = 0; exp_clip_b = 0;
    endtask

    task automatic test_corners();
        send_a(-3, 3, 3, -3, 1'b1);
        send_a(3, -3, -1, 1, 1'b1);
        send_a(-1, 1, 1, -1, 1'b1);
        drain();
        idle(2);
        n_vec++;
        if (data_a !== last_data_a) begin
            n_bad++;
            $display("FAIL hold: data_out got %h, required %h while idle", data_a, last_data_a);
        end
        check_counts("corners");
    endtask

    task automatic test_boundaries();
        send_a(2, 0, 1, 0, 1'b1);
        send_a(-4, 4, -2, -2, 1'b1);
        send_a(0, 2, 3, -4, 1'b1);
        drain();
        check_counts("boundaries");
    endtask

    task automatic test_clip();
        send_b(100, -128);
        drain();
        check_counts("clip_first");
        send_b(-128, 127);
        send_b(5, -5);
        send_b(-16, 15);
        send_b(15, -16);
        drain();
        check_counts("clip_more");
    endtask

    task automatic test_back_to_back_reset();
        send_a(-3, 1, 2, 2, 1'b1);
        send_a(1, -1, -2, 0, 1'b1);
        send_a(3, 3, 0, -3, 1'b1);
        send_a(-2, 0, 1, 3, 1'b1);
        idle(1);
        send_a(3, -3, 3, -3, 1'b0);
        rst = 1'b1;
        send_a(-3, 3, -3, 3, 1'b0);
        check_zero("flush");
        rst = 1'b0;
        exp_sym_a = 0; exp_clip_a = 0; exp_sym_b = 0; exp_clip_b = 0;
        idle(4);
        check_counts("flush");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            send_a(int'($urandom_range(12)) - 6, int'($urandom_range(12)) - 6,
                   int'($urandom_range(12)) - 6, int'($urandom_range(12)) - 6, 1'b1);
        end
        drain();
        check_counts("saturate");
    endtask

    task automatic test_clr_stats();
        send_a(5, 0, 0, 0, 1'b1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        exp_sym_a = 1;
        exp_clip_a = 1;
        drain();
        check_counts("clr_coincident");
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        exp_sym_a = 0;
        exp_clip_a = 0;
        idle(1);
        check_counts("clr_idle");
    endtask

    initial begin
        test_reset();
        test_corners();
        test_boundaries();
        test_clip();
        test_back_to_back_reset();
        test_saturation();
        test_clr_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
